// File: rtl/pio_write_arbiter.sv
// rtl/pio_write_arbiter.sv - two-requester round-robin byte writer to a PIO slave with optional verify read
//
// Ports:
//   clk, reset_n                    clock, asynchronous active-low reset
//   req0_valid/req0_data/req0_ready requester 0 byte handshake (valid & ready)
//   req1_valid/req1_data/req1_ready requester 1 byte handshake (valid & ready)
//   avm_address/avm_chipselect/     PIO slave bus: one write cycle, then an
//   avm_write_n/avm_writedata/      optional one-cycle verify read of address 0
//   avm_readdata
//   done, done_id                   one-cycle completion pulse and served requester
//   mismatch                        verify result of the last transaction
//   err_count                       saturating count of verify mismatches

module pio_write_arbiter #(
    parameter int DATA_W   = 8,
    parameter int READBACK = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [1:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    output logic              done,
    output logic              done_id,
    output logic              mismatch,
    output logic [7:0]        err_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] cap_data;
    logic              cap_id;
    logic              last_gnt;
    logic              done_id_r;
    logic              mismatch_r;
    logic [7:0]        err_r;
    logic              gnt1;
    logic              hs0;
    logic              hs1;
    logic              rd_diff;
    logic [31:0]       wd_ext;

    // Only the low DATA_W bits of the readback take part in the compare.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata;

    // Requester 1 wins when alone, or in contention when requester 0 was granted last.
    assign gnt1    = req1_valid & (~req0_valid | ~last_gnt);
    assign hs0     = req0_valid & req0_ready;
    assign hs1     = req1_valid & req1_ready;
    assign rd_diff = (avm_readdata[DATA_W-1:0] != cap_data);

    always_comb begin
        wd_ext               = '0;
        wd_ext[DATA_W-1:0]   = cap_data;
    end

    always_comb begin
        state_nxt      = state;
        req0_ready     = 1'b0;
        req1_ready     = 1'b0;
        avm_address    = 2'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        done           = 1'b0;
        case (state)
            IDLE: begin
                // Ready is masked by reset so no handshake is reported while held in reset.
                req0_ready = reset_n & req0_valid & ~gnt1;
                req1_ready = reset_n & gnt1;
                if (req0_valid || req1_valid) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                avm_chipselect = 1'b1;
                avm_write_n    = 1'b0;
                state_nxt      = (READBACK != 0) ? VERIFY : DONE;
            end
            VERIFY: begin
                avm_chipselect = 1'b1;
                state_nxt      = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cap_data   <= '0;
            cap_id     <= 1'b0;
            last_gnt   <= 1'b1;
            done_id_r  <= 1'b0;
            mismatch_r <= 1'b0;
            err_r      <= 8'd0;
        end else begin
            state <= state_nxt;
            if (hs0 || hs1) begin
                cap_data <= hs1 ? req1_data : req0_data;
                cap_id   <= hs1;
                last_gnt <= hs1;
            end
            if (state == VERIFY) begin
                mismatch_r <= rd_diff;
                if (rd_diff && (err_r != 8'hFF)) begin
                    err_r <= err_r + 8'd1;
                end
            end else if (state == WRITE && READBACK == 0) begin
                mismatch_r <= 1'b0;
            end
            // done_id and mismatch are refreshed only on entry to DONE and held afterwards.
            if (state != DONE && state_nxt == DONE) begin
                done_id_r <= cap_id;
            end
        end
    end

    assign avm_writedata = wd_ext;
    assign done_id       = done_id_r;
    assign mismatch      = mismatch_r;
    assign err_count     = err_r;

endmodule

// File: tb/tb_pio_write_arbiter.sv
// tb/tb_pio_write_arbiter.sv - scoreboard bench for pio_write_arbiter, READBACK=1 and READBACK=0 instances

module tb_pio_write_arbiter;

    typedef struct {
        int         inst;
        bit         v0;
        bit         v1;
        logic [7:0] d0;
        logic [7:0] d1;
        bit         exp_id;
    } vec_t;

    typedef struct {
        int         inst;
        bit         id;
        logic [7:0] data;
        bit         mis;
        int         hs_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  v0, v1, r0, r1, cs, wn, dn, did, mis;
    logic [7:0]  rq0_data [2];
    logic [7:0]  rq1_data [2];
    logic [1:0]  addr0, addr1;
    logic [31:0] wd0, wd1, rd0, rd1, mem0, mem1;
    logic [7:0]  err0, err1;
    logic        fault;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          model_err [2];
    exp_t        sb [$];
    vec_t        vecs [13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pio_write_arbiter #(.DATA_W(8), .READBACK(1)) u_rb1 (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(v0[0]), .req0_data(rq0_data[0]), .req0_ready(r0[0]),
        .req1_valid(v1[0]), .req1_data(rq1_data[0]), .req1_ready(r1[0]),
        .avm_address(addr0), .avm_chipselect(cs[0]), .avm_write_n(wn[0]),
        .avm_writedata(wd0), .avm_readdata(rd0),
        .done(dn[0]), .done_id(did[0]), .mismatch(mis[0]), .err_count(err0)
    );

    pio_write_arbiter #(.DATA_W(8), .READBACK(0)) u_rb0 (
        .clk(clk), .reset_n(rst_n),
        .req0_valid(v0[1]), .req0_data(rq0_data[1]), .req0_ready(r0[1]),
        .req1_valid(v1[1]), .req1_data(rq1_data[1]), .req1_ready(r1[1]),
        .avm_address(addr1), .avm_chipselect(cs[1]), .avm_write_n(wn[1]),
        .avm_writedata(wd1), .avm_readdata(rd1),
        .done(dn[1]), .done_id(did[1]), .mismatch(mis[1]), .err_count(err1)
    );

    // PIO slave models: echo the last written word, or read zero when faulty.
    always @(posedge clk) begin
        if (cs[0] && !wn[0]) mem0 <= wd0;
        if (cs[1] && !wn[1]) mem1 <= wd1;
    end
    assign rd0 = fault ? 32'h0 : mem0;
    assign rd1 = mem1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                automatic logic [31:0] wdk   = (k == 1) ? wd1 : wd0;
                automatic logic [1:0]  addrk = (k == 1) ? addr1 : addr0;
                automatic logic [7:0]  errk  = (k == 1) ? err1 : err0;
                automatic exp_t        e;
                if (cs[k]) begin
                    if (sb.size() == 0 || sb[0].inst != k) begin
                        chk("unexpected_cs", {31'h0, cs[k]}, 32'h0);
                    end else if (!wn[k]) begin
                        chk("write_data", wdk, {24'h0, sb[0].data});
                        chk("write_cycle", cyc - sb[0].hs_cyc, 1);
                        chk("write_addr", {30'h0, addrk}, 32'h0);
                    end else if (k == 1) begin
                        chk("rb0_has_verify", {31'h0, wn[k]}, 32'h0);
                    end else begin
                        chk("verify_cycle", cyc - sb[0].hs_cyc, 2);
                        chk("verify_addr", {30'h0, addrk}, 32'h0);
                    end
                end
                if (dn[k]) begin
                    if (sb.size() == 0 || sb[0].inst != k) begin
                        chk("spurious_done", {31'h0, dn[k]}, 32'h0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_id", {31'h0, did[k]}, {31'h0, e.id});
                        chk("mismatch", {31'h0, mis[k]}, {31'h0, e.mis});
                        chk("done_latency", cyc - e.hs_cyc, (k == 1) ? 2 : 3);
                        if (e.mis && model_err[k] < 255) model_err[k]++;
                        chk("err_count", {24'h0, errk}, model_err[k]);
                    end
                end
                if ((v0[k] && r0[k]) || (v1[k] && r1[k])) begin
                    e.inst   = k;
                    e.id     = v1[k] & r1[k];
                    e.data   = e.id ? rq1_data[k] : rq0_data[k];
                    e.mis    = (k == 0) && fault && (e.data != 8'h00);
                    e.hs_cyc = cyc;
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic do_txn(input int k, input bit a, input bit b,
                          input logic [7:0] da, input logic [7:0] db, input bit exp_id);
        int seen;
        int n;
        @(posedge clk);
        #1;
        v0[k] = a; v1[k] = b; rq0_data[k] = da; rq1_data[k] = db;
        seen = 0;
        for (n = 0; n < 8; n++) begin
            @(negedge clk);
            if ((v0[k] && r0[k]) || (v1[k] && r1[k])) begin
                seen = 1;
                break;
            end
        end
        if (seen == 0) chk("handshake_timeout", seen, 1);
        else chk("grant_id", {31'h0, r1[k] & v1[k]}, {31'h0, exp_id});
        @(posedge clk);
        #1;
        v0[k] = 1'b0; v1[k] = 1'b0;
        rq0_data[k] = 8'($urandom); rq1_data[k] = 8'($urandom);
        n = 0;
        while (!dn[k] && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!dn[k]) chk("done_timeout", {31'h0, dn[k]}, 32'h1);
    endtask

    task automatic b2b(input int k, input int gap);
        int prev;
        int cnt;
        int n;
        @(posedge clk);
        #1;
        v1[k] = 1'b1; rq1_data[k] = 8'hFF;
        prev = 0; cnt = 0; n = 0;
        while (cnt < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (v1[k] && r1[k]) begin
                if (cnt > 0) chk("b2b_gap", cyc - prev, gap);
                prev = cyc;
                cnt++;
            end
        end
        chk("b2b_count", cnt, 3);
        @(posedge clk);
        #1;
        v1[k] = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_drain", sb.size(), 0);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; fault = 1'b0;
        v0 = 2'b00; v1 = 2'b00;
        rq0_data[0] = 8'h00; rq0_data[1] = 8'h00; rq1_data[0] = 8'h00; rq1_data[1] = 8'h00;
        model_err[0] = 0; model_err[1] = 0;

        vecs[0]  = '{0, 1, 1, 8'h11, 8'h22, 1'b0};
        vecs[1]  = '{0, 1, 1, 8'h33, 8'h44, 1'b1};
        vecs[2]  = '{0, 1, 1, 8'h55, 8'h66, 1'b0};
        vecs[3]  = '{0, 1, 1, 8'h77, 8'h88, 1'b1};
        vecs[4]  = '{0, 1, 0, 8'h5A, 8'h00, 1'b0};
        vecs[5]  = '{0, 1, 0, 8'h3C, 8'h00, 1'b0};
        vecs[6]  = '{0, 0, 1, 8'h00, 8'h7E, 1'b1};
        vecs[7]  = '{0, 0, 1, 8'h00, 8'h81, 1'b1};
        vecs[8]  = '{0, 1, 1, 8'hC3, 8'h99, 1'b0};
        vecs[9]  = '{1, 0, 1, 8'h00, 8'hFF, 1'b1};
        vecs[10] = '{1, 1, 1, 8'h10, 8'h20, 1'b0};
        vecs[11] = '{1, 1, 1, 8'h30, 8'h40, 1'b1};
        vecs[12] = '{1, 1, 0, 8'hA5, 8'h00, 1'b0};

        // Reset state, with a requester already valid.
        v0[0] = 1'b1; v1[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ready0", {30'h0, r0}, 32'h0);
        chk("rst_ready1", {30'h0, r1}, 32'h0);
        chk("rst_cs", {30'h0, cs}, 32'h0);
        chk("rst_write_n", {30'h0, wn}, 32'h3);
        chk("rst_addr", {28'h0, addr1, addr0}, 32'h0);
        chk("rst_wdata0", wd0, 32'h0);
        chk("rst_wdata1", wd1, 32'h0);
        chk("rst_done", {26'h0, dn, did, mis}, 32'h0);
        chk("rst_err", {16'h0, err1, err0}, 32'h0);
        v0 = 2'b00; v1 = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            do_txn(vecs[i].inst, vecs[i].v0, vecs[i].v1, vecs[i].d0, vecs[i].d1, vecs[i].exp_id);
        end

        b2b(1, 3);
        b2b(0, 4);

        // Faulty slave: verify reads zero.
        fault = 1'b1;
        do_txn(0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0);
        chk("err_after_first", {24'h0, err0}, 32'd1);
        chk("mismatch_first", {31'h0, mis[0]}, 32'h1);
        for (int i = 0; i < 299; i++) do_txn(0, 1'b1, 1'b0, 8'h81, 8'h00, 1'b0);
        chk("err_saturated", {24'h0, err0}, 32'd255);
        fault = 1'b0;

        // Reset in the middle of a write.
        @(posedge clk);
        #1;
        v0[0] = 1'b1; rq0_data[0] = 8'h33;
        @(negedge clk);
        chk("abort_hs", {31'h0, r0[0]}, 32'h1);
        @(posedge clk);
        #1;
        v0[0] = 1'b0;
        @(negedge clk);
        chk("abort_in_write", {30'h0, cs[0], wn[0]}, 32'h2);
        #1;
        rst_n = 1'b0;
        sb.delete();
        model_err[0] = 0; model_err[1] = 0;
        #1;
        chk("abort_cs", {31'h0, cs[0]}, 32'h0);
        chk("abort_write_n", {31'h0, wn[0]}, 32'h1);
        chk("abort_err", {24'h0, err0}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (dn[0]) dcnt++;
        end
        chk("abort_no_done", dcnt, 0);
        do_txn(0, 1'b1, 1'b1, 8'h5A, 8'h6B, 1'b0);
        chk("after_abort_wdata", wd0, 32'h0000005A);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pio_write_arbiter.md
PIO_WRITE_ARBITER -- requirements
Module: pio_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the width of the output-port byte written to the PIO slave.
REQ-002 The block SHALL have parameter READBACK, default 1, meaning a verify read follows each write (1) or does not (0).
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low; ports clk and reset_n.
REQ-004 Ports SHALL be:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  DATA_W  requester 0 byte
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  DATA_W  requester 1 byte
- req1_ready  out  1  requester 1 accepted this cycle
- avm_address  out  2  PIO slave address
- avm_chipselect  out  1  PIO slave select
- avm_write_n  out  1  PIO slave write strobe, active-low
- avm_writedata  out  32  PIO slave write data
- avm_readdata  in  32  PIO slave read data, combinational from address
- done  out  1  one-cycle pulse, transaction complete
- done_id  out  1  requester served by the last transaction
- mismatch  out  1  last verify failed; valid with done, held until next done
- err_count  out  8  saturating mismatch count

Function
REQ-005 The FSM SHALL have states IDLE, WRITE, VERIFY and DONE.
REQ-006 In IDLE, the arbiter SHALL grant one valid requester; if both are valid it SHALL grant the one not granted last (round-robin).
REQ-007 reqN_ready SHALL be high only in IDLE for the granted requester; the handshake is valid & ready in the same cycle.
REQ-008 The block SHALL capture reqN_data and the requester id on handshake, then go to WRITE.
REQ-009 After handshake the requester MAY change its data; a requester SHALL hold valid until ready, and the block shall not depend on this.
REQ-010 WRITE SHALL last exactly 1 cycle with chipselect=1, write_n=0, address=0 and writedata = zero-extended captured byte.
REQ-011 With READBACK=1, WRITE SHALL go to VERIFY; with READBACK=0, WRITE SHALL go to DONE.
REQ-012 VERIFY SHALL last exactly 1 cycle with chipselect=1, write_n=1 and address=0.
REQ-013 At the end of VERIFY the block SHALL register mismatch = (avm_readdata[DATA_W-1:0] != captured byte).
REQ-014 DONE SHALL last 1 cycle with done=1 and done_id = captured id, then go to IDLE; chipselect=0 and write_n=1 in DONE.
REQ-015 With READBACK=0, mismatch SHALL be 0 at every done.
REQ-016 err_count SHALL increment by 1 on each mismatch and saturate at 255, with no wrap.
REQ-017 Latency, handshake at cycle 0: WRITE at cycle 1, VERIFY at 2, done at 3, next handshake possible at 4 (READBACK=1); done at 2 and next handshake at 3 (READBACK=0).
REQ-018 avm_* outputs SHALL be decoded from registered state and captured data only, with no combinational path from req inputs.
REQ-019 Outside WRITE and VERIFY the block SHALL drive chipselect=0, write_n=1 and address=0; avm_writedata holds its last value.
REQ-020 Requests arriving outside IDLE SHALL be ignored (ready=0) and not lost: they are granted when IDLE is reached if still valid.
REQ-021 The round-robin pointer SHALL update only on handshake; a lone valid requester SHALL be granted every time.

Reset
REQ-022 On reset_n=0 the block SHALL go immediately to IDLE, asynchronously.
REQ-023 On reset, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, done=0, done_id=0, mismatch=0, err_count=0 and req*_ready=0.
REQ-024 On reset the round-robin pointer SHALL be set so that requester 0 wins the first contention.
REQ-025 A reset during WRITE or VERIFY SHALL abort the transaction with no done pulse; the captured byte is discarded.

Verification
REQ-026 Single request: req0 0x5A, slave model echoes -> write at cycle 1 with writedata 0x0000005A, done at cycle 3, done_id=0, mismatch=0.
REQ-027 Contention: req0 and req1 valid together for 4 transactions -> grant order 0,1,0,1 and done_id matches the order.
REQ-028 Faulty slave: readdata forced to 0x00 while writing 0x81 -> mismatch=1 at done, err_count=1; 300 such writes -> err_count=255.
REQ-029 READBACK=0: req1 0xFF -> no VERIFY cycle, done at cycle 2, mismatch=0, back-to-back requests spaced 3 cycles apart.
REQ-030 Reset mid-WRITE -> next cycle chipselect=0 and write_n=1, no done pulse, err_count=0, and a later req0 is served normally.
